uart_tx: RTL and testbench

// - UART transmitter, companion to the UART receive path: serialises bytes onto tx, LSB first, 1 start bit,
//   8 data bits, optional parity, 1 or 2 stop bits.
// - Sits between a byte-producing client (valid/ready) and the board UART TX pin.
// - A small input FIFO decouples the client so back-to-back frames go out with no idle gap.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 74 +++++++
 rtl/uart_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: data width, default line rate and the transmit
// FSM state encoding. The receive path uses the same defaults.
package uart_tx_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Parity bit for a data byte: even parity when odd=0, odd parity when odd=1.
    function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data,
                                        input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO in front of the transmitter. Push is refused while
// full; the full flag is a flop so the client-facing ready has no comb path.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = UART_DATA_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic [AW:0]   w_count_next;
    logic          w_push;
    logic          w_pop;

    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && (r_count != '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = r_full;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array is written only on push.
    // NOTE: the array has no reset; stale entries are never read because the pointers and count are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, count and the registered full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or
// 2 stop bits. The line, busy and done outputs are flops fed from the current
// state, so they trail the FSM by one clock and never glitch.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    // Must be within 4..65535 so the 16-bit bit timer can hold it.
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [15:0]            r_clk_cnt;
    logic [2:0]             r_bit_idx;
    logic                   r_stop_cnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_pop;
    logic [UART_DATA_W-1:0] w_fifo_data;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_bit_last;
    logic                   w_stop_last;
    logic                   w_line;
    logic                   w_frame_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    assign w_bit_last  = (r_clk_cnt == LAST_CNT);
    assign w_stop_last = (STOP_BITS == 2) ? r_stop_cnt : 1'b1;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state, FIFO pop request and the line level for the current bit.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_line       = 1'b1;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_line = 1'b0;
                if (w_bit_last) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_line = r_shift[r_bit_idx];
                if (w_bit_last && (r_bit_idx == 3'd7)) begin
                    w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_line = r_parity;
                if (w_bit_last) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_line = 1'b1;
                if (w_bit_last && w_stop_last) begin
                    w_frame_end = 1'b1;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit timer, data bit index and stop bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || w_bit_last) r_clk_cnt <= '0;
            else                                    r_clk_cnt <= r_clk_cnt + 16'd1;

            if (r_state != ST_DATA)  r_bit_idx <= '0;
            else if (w_bit_last)     r_bit_idx <= r_bit_idx + 3'd1;

            if (r_state != ST_STOP)  r_stop_cnt <= 1'b0;
            else if (w_bit_last)     r_stop_cnt <= !w_stop_last;
        end
    end

    // Byte and its parity are captured on the pop edge only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_shift  <= w_fifo_data;
            r_parity <= parity_bit(w_fifo_data, PARITY_ODD != 0);
        end
    end

    // Registered line, busy and done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_line;
            r_busy <= (r_state != ST_IDLE);
            r_done <= w_frame_end;
        end
    end

    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign tx_ready = !w_fifo_full;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O2) at 10 clks per bit,
// checked every clock against a frame-timeline model of the serial line.
module tb_uart_tx;

    localparam int         NCFG  = 3;
    localparam int         CPB   = 10;
    localparam int         DEPTH = 4;
    localparam logic [2:0] PEN   = 3'b110;   // cfg0 no parity, cfg1/cfg2 parity
    localparam logic [2:0] PODD  = 3'b100;   // cfg2 odd parity

    typedef struct {
        logic [7:0] data;
        int         start;   // first edge after which the start bit is on the line
    } frame_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [7:0]      tx_data [NCFG];
    logic [NCFG-1:0] tx_valid;
    logic [NCFG-1:0] tx_ready;
    logic [NCFG-1:0] tx;
    logic [NCFG-1:0] tx_busy;
    logic [NCFG-1:0] tx_done;

    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    frame_t          fr [NCFG][16];
    int              head [NCFG];
    int              tail [NCFG];
    int              last_end [NCFG];
    logic [NCFG-1:0] accepted;

    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : g_dut
            uart_tx #(
                .CLK_FREQ   (1000),
                .BAUD_RATE  (100),
                .PARITY_EN  (PEN[g] ? 1 : 0),
                .PARITY_ODD (PODD[g] ? 1 : 0),
                .STOP_BITS  ((g == 0) ? 1 : 2),
                .FIFO_DEPTH (DEPTH)
            ) u_dut (
                .clk      (clk),
                .reset_n  (reset_n),
                .tx_data  (tx_data[g]),
                .tx_valid (tx_valid[g]),
                .tx_ready (tx_ready[g]),
                .tx       (tx[g]),
                .tx_busy  (tx_busy[g]),
                .tx_done  (tx_done[g])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int c);
        return (10 + (PEN[c] ? 1 : 0) + ((c == 0) ? 0 : 1)) * CPB;
    endfunction

    // Line level of bit slot k within a frame carrying byte d.
    function automatic logic line_bit(input int c, input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if ((k == 9) && PEN[c]) return (^d) ^ PODD[c];
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCFG; c++) begin
            head[c]     = 0;
            tail[c]     = 0;
            last_end[c] = 0;
        end
    endtask

    // A byte accepted at edge t starts two edges later, or right after the previous frame.
    task automatic model_accept(input int c, input logic [7:0] d, input int t);
        int s;
        s = (t + 2 > last_end[c]) ? t + 2 : last_end[c];
        fr[c][tail[c] % 16].data  = d;
        fr[c][tail[c] % 16].start = s;
        tail[c]++;
        last_end[c] = s + frame_len(c);
    endtask

    // Expected {tx, tx_busy, tx_done, tx_ready} after edge t.
    task automatic model_expect(input int c, input int t, output logic [3:0] e);
        int     occ;
        logic   e_tx, e_busy, e_done;
        frame_t f;
        while ((head[c] != tail[c]) &&
               (fr[c][head[c] % 16].start + frame_len(c) <= t)) head[c]++;
        occ    = 0;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        for (int i = head[c]; i < tail[c]; i++) begin
            if (fr[c][i % 16].start - 1 > t) occ++;   // not yet popped
        end
        if (head[c] != tail[c]) begin
            f = fr[c][head[c] % 16];
            if (f.start <= t) begin
                e_busy = 1'b1;
                e_tx   = line_bit(c, f.data, (t - f.start) / CPB);
                e_done = (t == f.start + frame_len(c) - 1);
            end
        end
        e = {e_tx, e_busy, e_done, (occ < DEPTH)};
    endtask

    // One clock: note acceptances at the coming edge, then check all outputs.
    task automatic tick();
        logic [NCFG-1:0] acc;
        logic [3:0]      e;
        for (int c = 0; c < NCFG; c++) acc[c] = tx_valid[c] && tx_ready[c] && reset_n;
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            if (acc[c]) model_accept(c, tx_data[c], cyc);
            model_expect(c, cyc, e);
            check($sformatf("cfg%0d pins{tx,busy,done,ready}@%0d", c, cyc),
                  32'({tx[c], tx_busy[c], tx_done[c], tx_ready[c]}), 32'(e));
        end
        accepted = acc;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int c, input logic [7:0] d);
        int n;
        tx_valid[c] = 1'b1;
        tx_data[c]  = d;
        n = 0;
        accepted = '0;
        while (!accepted[c] && n < 2000) begin
            tick();
            n++;
        end
        check($sformatf("cfg%0d send %02h accepted", c, d), 32'(accepted[c]), 32'd1);
        tx_valid[c] = 1'b0;
    endtask

    task automatic random_traffic(input int n, input int odds);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCFG; c++) begin
                if (!tx_valid[c] && ($urandom_range(odds - 1, 0) == 0)) begin
                    tx_valid[c] = 1'b1;
                    tx_data[c]  = 8'($urandom);
                end
            end
            tick();
            for (int c = 0; c < NCFG; c++) if (accepted[c]) tx_valid[c] = 1'b0;
        end
        tx_valid = '0;
    endtask

    initial begin
        int n;
        int t0;
        tx_valid = '0;
        for (int c = 0; c < NCFG; c++) tx_data[c] = 8'h00;
        model_clear();
        accepted = '0;

        // Reset state, while reset is held.
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCFG; c++)
            check($sformatf("cfg%0d reset pins", c),
                  32'({tx[c], tx_busy[c], tx_done[c], tx_ready[c]}), 32'(4'b1001));
        #2 reset_n = 1'b1;
        idle(5);

        // Single 8N1 byte, then two bytes back to back.
        send(0, 8'h55);
        idle(120);
        send(0, 8'hA5);
        send(0, 8'h3C);
        idle(230);

        // Hold valid for seven bytes from idle; ready drops once the FIFO fills.
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'($urandom);
        n = 0;
        for (int i = 0; i < 2000 && n < 7; i++) begin
            tick();
            if (accepted[0]) begin
                n++;
                tx_data[0] = 8'($urandom);
            end
        end
        tx_valid[0] = 1'b0;
        check("burst bytes accepted", 32'(n), 32'd7);
        idle(720);

        // Parity with two stop bits, even and odd.
        send(1, 8'h07);
        send(2, 8'h07);
        idle(140);

        // Reset asserted during data bit 3 of a frame.
        send(0, 8'($urandom));
        t0 = cyc;
        for (int i = 0; i < 200 && cyc < t0 + 2 + 45; i++) tick();
        check("reached data bit 3", 32'(cyc), 32'(t0 + 47));
        #2 reset_n = 1'b0;
        #1;
        check("async reset pins", 32'({tx[0], tx_busy[0], tx_done[0], tx_ready[0]}), 32'(4'b1001));
        model_clear();
        idle(3);
        #2 reset_n = 1'b1;
        idle(150);

        // Random traffic: sparse, then dense enough to fill the FIFOs.
        random_traffic(800, 40);
        random_traffic(800, 2);
        idle(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
